// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point alignment datapath: default field
// widths, derived vector widths and the aligner state encoding.
package fp_pkg;

    localparam int DEF_EXP_WIDTH      = 8;
    localparam int DEF_MANTISSA_WIDTH = 23;
    localparam int GRS_WIDTH          = DEF_MANTISSA_WIDTH + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } align_state_e;

    // Mantissa with hidden bit plus guard, round and sticky positions.
    function automatic int grs_width(input int mantissa_width);
        return mantissa_width + 4;
    endfunction

    // Smallest counter that can hold the largest useful shift (mantissa_width + 3).
    function automatic int shift_cnt_width(input int mantissa_width);
        return $clog2(mantissa_width + 4);
    endfunction

endpackage

// File: rtl/mantissa_aligner_exp_compare.sv
// Combinational exponent comparison: picks the larger exponent, flags a swap
// when b is strictly larger, and produces the clamped alignment shift count.
module exp_compare #(
    parameter int EXP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 5,
    parameter int MAX_SHIFT  = 26
) (
    input  logic [EXP_WIDTH-1:0] a_e_in,
    input  logic [EXP_WIDTH-1:0] b_e_in,
    output logic                 swap_out,
    output logic [EXP_WIDTH-1:0] big_e_out,
    output logic [CNT_WIDTH-1:0] shift_out
);

    logic [EXP_WIDTH-1:0] diff_s;

    // Select the common exponent and clamp the distance to the point where every
    // shifted-out bit already sits in sticky.
    always_comb begin
        swap_out  = 1'b0;
        big_e_out = a_e_in;
        diff_s    = a_e_in - b_e_in;
        shift_out = {CNT_WIDTH{1'b0}};
        if (b_e_in > a_e_in) begin
            swap_out  = 1'b1;
            big_e_out = b_e_in;
            diff_s    = b_e_in - a_e_in;
        end else begin
            swap_out  = 1'b0;
            big_e_out = a_e_in;
            diff_s    = a_e_in - b_e_in;
        end
        if (int'(diff_s) > MAX_SHIFT) begin
            shift_out = CNT_WIDTH'(MAX_SHIFT);
        end else begin
            shift_out = CNT_WIDTH'(diff_s);
        end
    end

endmodule

// File: rtl/mantissa_aligner.sv
// Aligns the smaller-exponent mantissa to the larger exponent one bit per cycle,
// collecting shifted-out bits into guard/round/sticky, with valid/ready handshakes.
module mantissa_aligner
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH      = DEF_EXP_WIDTH,
    parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic [EXP_WIDTH-1:0]        a_e_in,
    input  logic [EXP_WIDTH-1:0]        b_e_in,
    input  logic [MANTISSA_WIDTH:0]     a_m_in,
    input  logic [MANTISSA_WIDTH:0]     b_m_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [EXP_WIDTH-1:0]        big_e_out,
    output logic [MANTISSA_WIDTH:0]     big_m_out,
    output logic [MANTISSA_WIDTH+3:0]   small_m_out,
    output logic                        swap_out
);

    localparam int GW        = grs_width(MANTISSA_WIDTH);
    localparam int CNT_W     = shift_cnt_width(MANTISSA_WIDTH);
    localparam int MAX_SHIFT = MANTISSA_WIDTH + 3;

    align_state_e           state_q, state_d;
    logic [EXP_WIDTH-1:0]   big_e_q, big_e_d;
    logic [MANTISSA_WIDTH:0] big_m_q, big_m_d;
    logic [GW-1:0]          small_m_q, small_m_d;
    logic                   swap_q, swap_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic                   ready_q, ready_d;

    logic                   cmp_swap_s;
    logic [EXP_WIDTH-1:0]   cmp_big_e_s;
    logic [CNT_W-1:0]       cmp_shift_s;

    exp_compare #(
        .EXP_WIDTH (EXP_WIDTH),
        .CNT_WIDTH (CNT_W),
        .MAX_SHIFT (MAX_SHIFT)
    ) u_exp_compare (
        .a_e_in    (a_e_in),
        .b_e_in    (b_e_in),
        .swap_out  (cmp_swap_s),
        .big_e_out (cmp_big_e_s),
        .shift_out (cmp_shift_s)
    );

    // Next-state and datapath update for the accept / shift / hold sequence.
    always_comb begin
        state_d   = state_q;
        big_e_d   = big_e_q;
        big_m_d   = big_m_q;
        small_m_d = small_m_q;
        swap_d    = swap_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        ready_d   = ready_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    swap_d  = cmp_swap_s;
                    big_e_d = cmp_big_e_s;
                    cnt_d   = cmp_shift_s;
                    if (cmp_swap_s) begin
                        big_m_d   = b_m_in;
                        small_m_d = {a_m_in, 3'b000};
                    end else begin
                        big_m_d   = a_m_in;
                        small_m_d = {b_m_in, 3'b000};
                    end
                    state_d = SHIFT;
                    ready_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    // Bits falling off the bottom are ORed into sticky.
                    small_m_d = {1'b0, small_m_q[GW-1:2], small_m_q[1] | small_m_q[0]};
                    cnt_d     = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                if (ready_in) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            big_e_q   <= {EXP_WIDTH{1'b0}};
            big_m_q   <= {(MANTISSA_WIDTH+1){1'b0}};
            small_m_q <= {GW{1'b0}};
            swap_q    <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            big_e_q   <= big_e_d;
            big_m_q   <= big_m_d;
            small_m_q <= small_m_d;
            swap_q    <= swap_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    assign big_e_out   = big_e_q;
    assign big_m_out   = big_m_q;
    assign small_m_out = small_m_q;
    assign swap_out    = swap_q;
    assign valid_out   = valid_q;
    assign ready_out   = ready_q;

endmodule

// File: doc/mantissa_aligner.md
MANTISSA_ALIGNER -- requirements
Module: mantissa_aligner

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, meaning stored fraction width (hidden bit excluded).
REQ-003 SHALL have port clk_in  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset_in  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports a_e_in, b_e_in  input  EXP_WIDTH  operand exponents.
REQ-006 SHALL have ports a_m_in, b_m_in  input  MANTISSA_WIDTH+1  operand mantissas, hidden bit supplied by upstream.
REQ-007 SHALL have ports valid_in  input  1 and ready_out  output  1  input handshake.
REQ-008 SHALL have ports valid_out  output  1 and ready_in  input  1  output handshake.
REQ-009 SHALL have port big_e_out  output  EXP_WIDTH  larger exponent (common exponent).
REQ-010 SHALL have port big_m_out  output  MANTISSA_WIDTH+1  mantissa of larger-exponent operand, unshifted.
REQ-011 SHALL have port small_m_out  output  MANTISSA_WIDTH+4  smaller-exponent mantissa, right-aligned, with guard, round, sticky in bits [2:0].
REQ-012 SHALL have port swap_out  output  1  high when b had the strictly larger exponent.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; ready_out high only in IDLE; valid_out high only in DONE.
REQ-014 SHALL accept an operation on an edge where state is IDLE and valid_in is high; valid_in outside IDLE is ignored.
REQ-015 On accept: swap = (b_e_in > a_e_in); equal exponents give swap=0; big operand registered to big_e/big_m; small vector loaded as {small_m, 3'b000}.
REQ-016 On accept: shift count d = big_e - small_e (unsigned, EXP_WIDTH bits), clamped to MANTISSA_WIDTH+3; state goes to SHIFT.
REQ-017 In SHIFT with d>0, each edge: vector v becomes {0, v[MSB:2], v[1]|v[0]}; d decrements.
REQ-018 In SHIFT with d==0, next edge goes to DONE; no shift that cycle.
REQ-019 Latency: accept on edge N gives valid_out high after edge N+d+1 (clamped d); d=0 gives 1 cycle.
REQ-020 Clamp is exact: after MANTISSA_WIDTH+3 shifts all nonzero bits reside in sticky; further shifts would not change the result.
REQ-021 In DONE, all outputs SHALL stay stable while ready_in is low, for any number of cycles.
REQ-022 On an edge with valid_out and ready_in both high, state goes to IDLE; next accept is possible on the following edge.
REQ-023 Zero or denormal operands SHALL NOT be special-cased; the datapath treats them as ordinary bit patterns.

Reset
REQ-024 reset_in high on an edge SHALL force IDLE and zero big_e_out, big_m_out, small_m_out, swap_out, the shift counter and valid_out; ready_out is high after that edge.
REQ-025 Reset during SHIFT or DONE SHALL discard the operation with no valid_out pulse; reset takes priority over a simultaneous accept.

Structure
REQ-026 SHALL take default widths, derived GRS width constant (MANTISSA_WIDTH+4) and the state enum from shared package fp_pkg.
REQ-027 SHALL place the exponent compare/swap/difference/clamp logic in combinational sub-module exp_compare.
REQ-028 Shift counter width SHALL be the minimum needed to hold MANTISSA_WIDTH+3.

Verification (defaults, 23-bit mantissa)
REQ-029 Align: a_e=130, a_m=0xC00000, b_e=128, b_m=0x800000 -> valid_out 3 edges after accept, swap=0, big_e=130, big_m=0xC00000, small_m=0x1000000.
REQ-030 Swap plus sticky: a_e=100, a_m=0x800004, b_e=106, b_m=0xFFFFFF -> swap=1, big_e=106, big_m=0xFFFFFF, small_m=0x0100001, latency 7.
REQ-031 Clamp: a_e=200, a_m=0x800000, b_e=160, b_m=0x800001 -> small_m=0x0000001, latency 27 (not 41).
REQ-032 Backpressure: ready_in low 5 cycles during DONE, valid_in pulsed meanwhile -> outputs unchanged, ready_out low, pulse ignored; handshake then ready_out high next cycle.
REQ-033 Reset mid-SHIFT with d=10 after 4 cycles -> all outputs zero, ready_out high next cycle, no valid_out; fresh op with d=0 completes in 1 cycle.
